// File: rtl/ch_readout_sequencer_pkg.sv
// Shared state encoding, register tags and width helpers for the channel readout sequencer.
package ch_readout_sequencer_pkg;

  typedef enum logic [2:0] {
    RDO_IDLE,
    RDO_WAIT_SLOT,
    RDO_SETUP,
    RDO_SHIFT,
    RDO_PUSH,
    RDO_FINISH
  } rdo_state_t;

  localparam logic [2:0] REG_CA   = 3'd0;
  localparam logic [2:0] REG_CB   = 3'd1;
  localparam logic [2:0] REG_CC   = 3'd2;
  localparam logic [2:0] REG_CD   = 3'd3;
  localparam logic [2:0] REG_CE   = 3'd4;
  localparam logic [2:0] REG_TCNT = 3'd5;
  localparam int         NUM_REGS = 6;

  // One FIFO entry is {data, channel tag, register tag}.
  function automatic int fifo_width(input int word_w, input int num_ch);
    return word_w + $clog2(num_ch) + 3;
  endfunction

endpackage

// File: rtl/readout_word_fifo.sv
// Synchronous word FIFO with a registered head and an occupancy count.
module readout_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != FULL) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    // The head register looks ahead; a word written into the head slot bypasses memory.
    head_d = head_q;
    if (count_d != '0) begin
      head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/ch_readout_sequencer.sv
// Walks every channel/register, deserialises CNT_SER into tagged words and queues them for SPI tx.
// state     | meaning
// IDLE      | waiting for READOUT_REQ
// WAIT_SLOT | waiting for a free FIFO slot before selecting the next register
// SETUP     | select settling time before the first serial bit
// SHIFT     | sampling WORD_W serial bits, MSB first
// PUSH      | writing the tagged word, advancing reg/ch
// FINISH    | DONE pulse, INST_READOUT dropped
module ch_readout_sequencer
  import ch_readout_sequencer_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int WORD_W     = 10,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      SPI_CLK,
  input  logic                      RST,
  input  logic                      READOUT_REQ,
  input  logic [NUM_CH-1:0]         CNT_SER,
  output logic                      INST_READOUT,
  output logic [2:0]                SELECT_REG,
  output logic [$clog2(NUM_CH)-1:0] CH_SEL,
  output logic [WORD_W-1:0]         WORD_DATA,
  output logic [$clog2(NUM_CH)-1:0] WORD_CH,
  output logic [2:0]                WORD_REG,
  output logic                      WORD_VALID,
  input  logic                      WORD_READY,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int FW      = fifo_width(WORD_W, NUM_CH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_MAX = (WORD_W > SETTLE) ? WORD_W : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] SHIFT_LOAD = TMR_W'(WORD_W - 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'((SETTLE > 1) ? SETTLE - 2 : 0);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [2:0]       LAST_REG   = 3'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  rdo_state_t        state_q;
  logic [CH_W-1:0]   ch_q;
  logic [2:0]        reg_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [WORD_W-1:0] shift_q;
  logic              inst_q;
  logic              busy_q;
  logic              done_q;
  logic [2:0]        sel_reg_q;
  logic [CH_W-1:0]   sel_ch_q;

  logic [FW-1:0]     head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;
  logic              pop;
  logic              push;
  logic              slot_free;

  assign pop       = fifo_valid && WORD_READY;
  assign push      = (state_q == RDO_PUSH);
  // A pop in the same cycle frees a slot; the reserved slot stays free until PUSH.
  assign slot_free = (fifo_count != FIFO_FULL) || pop;

  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RDO_IDLE;
      ch_q      <= '0;
      reg_q     <= REG_CA;
      tmr_q     <= '0;
      shift_q   <= '0;
      inst_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_reg_q <= REG_CA;
      sel_ch_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RDO_IDLE: begin
          if (READOUT_REQ) begin
            state_q <= RDO_WAIT_SLOT;
            ch_q    <= '0;
            reg_q   <= REG_CA;
            inst_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RDO_WAIT_SLOT: begin
          if (slot_free) begin
            sel_reg_q <= reg_q;
            sel_ch_q  <= ch_q;
            if (SETTLE > 1) begin
              state_q <= RDO_SETUP;
              tmr_q   <= SETUP_LOAD;
            end else begin
              state_q <= RDO_SHIFT;
              tmr_q   <= SHIFT_LOAD;
            end
          end
        end
        RDO_SETUP: begin
          if (tmr_q == '0) begin
            state_q <= RDO_SHIFT;
            tmr_q   <= SHIFT_LOAD;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        RDO_SHIFT: begin
          shift_q <= {shift_q[WORD_W-2:0], CNT_SER[sel_ch_q]};
          if (tmr_q == '0) begin
            state_q <= RDO_PUSH;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        RDO_PUSH: begin
          if (reg_q == LAST_REG) begin
            reg_q <= REG_CA;
            if (ch_q == LAST_CH) begin
              state_q <= RDO_FINISH;
              inst_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ch_q    <= ch_q + 1'b1;
              state_q <= RDO_WAIT_SLOT;
            end
          end else begin
            reg_q   <= reg_q + 1'b1;
            state_q <= RDO_WAIT_SLOT;
          end
        end
        RDO_FINISH: begin
          state_q <= RDO_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= RDO_IDLE;
      endcase
    end
  end

  readout_word_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (SPI_CLK),
    .rst_i       (RST),
    .push_i      (push),
    .push_data_i ({shift_q, sel_ch_q, sel_reg_q}),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign INST_READOUT = inst_q;
  assign SELECT_REG   = sel_reg_q;
  assign CH_SEL       = sel_ch_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign WORD_DATA    = head[FW-1 -: WORD_W];
  assign WORD_CH      = head[3 +: CH_W];
  assign WORD_REG     = head[2:0];
  assign WORD_VALID   = fifo_valid;

endmodule

// File: tb/tb_ch_readout_sequencer.sv
// Bench for ch_readout_sequencer: channel bit-stream model, word scoreboard and directed corner cases.
`timescale 1ns/1ps
module tb_ch_readout_sequencer;
  import ch_readout_sequencer_pkg::*;

  localparam int NUM_CH     = 6;
  localparam int WORD_W     = 10;
  localparam int SETTLE     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int N_WORDS    = NUM_CH * NUM_REGS;
  localparam int LAT        = 1 + (SETTLE - 1) + WORD_W + 1;

  logic              SPI_CLK = 1'b0;
  logic              RST = 1'b0;
  logic              READOUT_REQ = 1'b0;
  logic [NUM_CH-1:0] CNT_SER = '0;
  logic              INST_READOUT;
  logic [2:0]        SELECT_REG;
  logic [CH_W-1:0]   CH_SEL;
  logic [WORD_W-1:0] WORD_DATA;
  logic [CH_W-1:0]   WORD_CH;
  logic [2:0]        WORD_REG;
  logic              WORD_VALID;
  logic              WORD_READY = 1'b0;
  logic              BUSY;
  logic              DONE;

  ch_readout_sequencer #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .SPI_CLK(SPI_CLK), .RST(RST), .READOUT_REQ(READOUT_REQ), .CNT_SER(CNT_SER),
    .INST_READOUT(INST_READOUT), .SELECT_REG(SELECT_REG), .CH_SEL(CH_SEL),
    .WORD_DATA(WORD_DATA), .WORD_CH(WORD_CH), .WORD_REG(WORD_REG),
    .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY), .BUSY(BUSY), .DONE(DONE)
  );

  always #12.5 SPI_CLK = ~SPI_CLK;

  typedef struct packed {
    logic [WORD_W-1:0] d;
    logic [2:0]        ch;
    logic [2:0]        r;
  } word_t;

  typedef struct {
    string             name;
    logic [WORD_W-1:0] pat;
    logic [WORD_W-1:0] exp;
  } pat_vec_t;

  int checks = 0;
  int failures = 0;
  int words_seen = 0;
  int done_seen = 0;
  int busy_cyc = 0;
  int cyc = 0;
  int rmode = 0;
  int acc_cyc[$];
  word_t exp_q[$];
  logic [WORD_W-1:0] tbl [NUM_CH][NUM_REGS];
  logic [2:0] reg_ids [NUM_REGS];
  pat_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Channels: a select change restarts the stream; the MSB is valid SETTLE edges after it.
  int phase = -100;
  logic inst_prev = 1'b0;
  logic [2:0] sel_prev = '0;
  logic [CH_W-1:0] ch_prev = '0;
  always @(posedge SPI_CLK) begin
    #1;
    if (INST_READOUT && !inst_prev) phase = -1;
    else if (SELECT_REG != sel_prev || CH_SEL != ch_prev) phase = 0;
    else phase = phase + 1;
    inst_prev = INST_READOUT;
    sel_prev  = SELECT_REG;
    ch_prev   = CH_SEL;
    for (int k = 0; k < NUM_CH; k++) begin
      int b;
      b = phase - (SETTLE - 1);
      if (b >= 0 && b < WORD_W && SELECT_REG < NUM_REGS)
        CNT_SER[k] = tbl[k][SELECT_REG][WORD_W-1-b];
      else
        CNT_SER[k] = 1'($urandom);
    end
  end

  always @(posedge SPI_CLK) begin
    cyc = cyc + 1;
    #1;
    case (rmode)
      1:       WORD_READY = 1'b1;
      2:       WORD_READY = 1'($urandom);
      default: WORD_READY = 1'b0;
    endcase
  end

  always @(negedge SPI_CLK) begin
    if (!RST) begin
      if (BUSY) busy_cyc++;
      if (DONE) done_seen++;
      if (WORD_VALID && WORD_READY) begin
        words_seen++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word actual=%0h required=none", {WORD_DATA, WORD_CH, WORD_REG});
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check($sformatf("word%0d", words_seen), 32'({WORD_DATA, WORD_CH, WORD_REG}), 32'(e));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge SPI_CLK);
    #1;
  endtask

  task automatic pulse_req;
    @(posedge SPI_CLK);
    #2 READOUT_REQ = 1'b1;
    @(posedge SPI_CLK);
    #2 READOUT_REQ = 1'b0;
  endtask

  task automatic reset_counters;
    words_seen = 0;
    done_seen  = 0;
    busy_cyc   = 0;
    acc_cyc.delete();
  endtask

  task automatic load_expected(input bit use_const, input logic [WORD_W-1:0] cval);
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < NUM_REGS; r++) begin
        word_t w;
        w.d  = use_const ? cval : tbl[ch][r];
        w.ch = 3'(ch);
        w.r  = reg_ids[r];
        exp_q.push_back(w);
      end
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (BUSY && n < limit) begin
      @(negedge SPI_CLK);
      n++;
    end
    #1;
    check({name, "_busy_timeout"}, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (WORD_VALID && n < limit) begin
      @(negedge SPI_CLK);
      n++;
    end
    #1;
    check({name, "_drain_timeout"}, 32'(WORD_VALID), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_inst"},  32'(INST_READOUT), 0);
    check({pfx, "_selreg"}, 32'(SELECT_REG), 0);
    check({pfx, "_chsel"}, 32'(CH_SEL), 0);
    check({pfx, "_wdata"}, 32'(WORD_DATA), 0);
    check({pfx, "_wch"},   32'(WORD_CH), 0);
    check({pfx, "_wreg"},  32'(WORD_REG), 0);
    check({pfx, "_valid"}, 32'(WORD_VALID), 0);
    check({pfx, "_busy"},  32'(BUSY), 0);
    check({pfx, "_done"},  32'(DONE), 0);
  endtask

  task automatic fill_ramp;
    for (int k = 0; k < NUM_CH; k++)
      for (int r = 0; r < NUM_REGS; r++) tbl[k][r] = 10'h3A0 + 10'(r) + 10'(k * 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    reg_ids = '{REG_CA, REG_CB, REG_CC, REG_CD, REG_CE, REG_TCNT};
    vecs[0] = '{"pat_001", 10'h001, 10'h001};
    vecs[1] = '{"pat_200", 10'h200, 10'h200};
    vecs[2] = '{"pat_3ff", 10'h3FF, 10'h3FF};
    vecs[3] = '{"tcnt_005", 10'h005, 10'h005};
    fill_ramp();

    #2 RST = 1'b1;
    #20;
    check_reset_outputs("reset");
    @(negedge SPI_CLK);
    #2 RST = 1'b0;

    // Ramp sweep with READY held high: order, tags, timing.
    rmode = 1;
    reset_counters();
    load_expected(1'b0, '0);
    pulse_req();
    wait_done("ramp", 2000);
    wait_drain("ramp", 100);
    check("ramp_words", words_seen, N_WORDS);
    check("ramp_done", done_seen, 1);
    check("ramp_busy_cycles", busy_cyc, N_WORDS * LAT + 1);
    bad = 0;
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != LAT) bad++;
    check("ramp_word_interval_bad", bad, 0);
    check("ramp_idle_selreg", 32'(SELECT_REG), 32'(REG_TCNT));
    check("ramp_idle_chsel", 32'(CH_SEL), NUM_CH - 1);
    check("ramp_idle_inst", 32'(INST_READOUT), 0);
    check("ramp_exp_left", exp_q.size(), 0);

    // Constant patterns (MSB-first ordering).
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < NUM_CH; k++)
        for (int r = 0; r < NUM_REGS; r++) tbl[k][r] = vecs[v].pat;
      reset_counters();
      load_expected(1'b1, vecs[v].exp);
      pulse_req();
      wait_done(vecs[v].name, 2000);
      wait_drain(vecs[v].name, 100);
      check({vecs[v].name, "_words"}, words_seen, N_WORDS);
      check({vecs[v].name, "_done"}, done_seen, 1);
    end

    // READY held low: FIFO fills, FSM parks, then drains with nothing lost.
    for (int k = 0; k < NUM_CH; k++)
      for (int r = 0; r < NUM_REGS; r++) tbl[k][r] = 10'($urandom);
    rmode = 0;
    reset_counters();
    load_expected(1'b0, '0);
    pulse_req();
    tick(120);
    check("park_words", words_seen, 0);
    check("park_valid", 32'(WORD_VALID), 1);
    check("park_inst", 32'(INST_READOUT), 1);
    check("park_busy", 32'(BUSY), 1);
    check("park_head", 32'({WORD_DATA, WORD_CH, WORD_REG}), 32'(exp_q[0]));
    tick(7);
    check("park_head_stable", 32'({WORD_DATA, WORD_CH, WORD_REG}), 32'(exp_q[0]));
    rmode = 1;
    tick(10);
    check("park_burst_words", words_seen, FIFO_DEPTH);
    wait_done("park", 2000);
    wait_drain("park", 100);
    check("park_total_words", words_seen, N_WORDS);
    check("park_done", done_seen, 1);

    // Random data and READY, with an extra request mid-sweep that must be ignored.
    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < NUM_CH; k++)
        for (int r = 0; r < NUM_REGS; r++) tbl[k][r] = 10'($urandom);
      rmode = 2;
      reset_counters();
      load_expected(1'b0, '0);
      pulse_req();
      tick($urandom_range(50, 400));
      pulse_req();
      wait_done($sformatf("rand%0d", it), 8000);
      wait_drain($sformatf("rand%0d", it), 400);
      check($sformatf("rand%0d_words", it), words_seen, N_WORDS);
      check($sformatf("rand%0d_done", it), done_seen, 1);
      check($sformatf("rand%0d_exp_left", it), exp_q.size(), 0);
    end

    // Reset while shifting ch2 reg3, then a clean restart from ch0 reg0.
    fill_ramp();
    rmode = 1;
    reset_counters();
    load_expected(1'b0, '0);
    pulse_req();
    n = 0;
    while (!(SELECT_REG == REG_CD && CH_SEL == 3'd2) && n < 3000) begin
      @(negedge SPI_CLK);
      n++;
    end
    check("find_ch2_reg3_timeout", 32'(n >= 3000), 0);
    tick(4);
    #3 RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_done_seen", done_seen, 0);
    exp_q.delete();
    tick(2);
    RST = 1'b0;
    reset_counters();
    load_expected(1'b0, '0);
    pulse_req();
    wait_done("restart", 2000);
    wait_drain("restart", 100);
    check("restart_words", words_seen, N_WORDS);
    check("restart_done", done_seen, 1);
    check("restart_busy_cycles", busy_cyc, N_WORDS * LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
